// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage feeding the main decoder, with a single-level
// external interrupt (synchronise, latch, vector, save EPC, return on eret).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR  = 32'h0000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        Branch,
    input  logic        BNE,
    input  logic        zero,
    input  logic        Jump,
    input  logic        Jr,
    input  logic        eret,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    input  logic        int_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        in_isr,
    output logic        int_ack
);

    logic [31:0]            pc_q, pc_d;
    logic [31:0]            epc_q, epc_d;
    logic                   in_isr_q, in_isr_d;
    logic                   int_ack_q, int_ack_d;
    logic                   pending_q, pending_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] seq_next;
    logic        taken_branch;
    logic        int_rise;
    logic        take_int;

    assign pc_plus4     = pc_q + 32'd4;
    assign branch_tgt   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_tgt     = {pc_plus4[31:28], instr_index, 2'b00};
    assign taken_branch = Branch & (BNE ? ~zero : zero);

    always_comb begin
        seq_next = pc_plus4;
        if (eret)
            seq_next = epc_q;
        else if (Jr)
            seq_next = rs_data;
        else if (Jump)
            seq_next = jump_tgt;
        else if (taken_branch)
            seq_next = branch_tgt;
    end

    // A new synchronised edge wins over the clear caused by taking an interrupt.
    assign take_int = pending_q & ~in_isr_q & ~stall & ~eret;
    assign int_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], int_req};
        edge_d    = sync_q[SYNC_STAGES-1];
        pending_d = int_rise | (pending_q & ~take_int);
    end

    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        in_isr_d  = in_isr_q;
        int_ack_d = 1'b0;
        if (stall) begin
            int_ack_d = 1'b0;
        end else if (take_int) begin
            epc_d     = seq_next;
            pc_d      = INT_VECTOR;
            in_isr_d  = 1'b1;
            int_ack_d = 1'b1;
        end else if (eret) begin
            pc_d     = epc_q;
            in_isr_d = 1'b0;
        end else begin
            pc_d = seq_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            in_isr_q  <= 1'b0;
            int_ack_q <= 1'b0;
            pending_q <= 1'b0;
            sync_q    <= '0;
            edge_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            in_isr_q  <= in_isr_d;
            int_ack_q <= int_ack_d;
            pending_q <= pending_d;
            sync_q    <= sync_d;
            edge_q    <= edge_d;
        end
    end

    assign pc      = pc_q;
    assign epc     = epc_q;
    assign in_isr  = in_isr_q;
    assign int_ack = int_ack_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the fetch/interrupt rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] VEC  = 32'h0000_0100;
    localparam int          SYNC = 2;

    logic        clk, rst, stall, Branch, BNE, zero, Jump, Jr, eret, int_req;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic [31:0] pc, pc_plus4, epc;
    logic        in_isr, int_ack;

    pc_fetch_unit #(
        .RESET_PC    (RPC),
        .INT_VECTOR  (VEC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .Branch      (Branch),
        .BNE         (BNE),
        .zero        (zero),
        .Jump        (Jump),
        .Jr          (Jr),
        .eret        (eret),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .int_req     (int_req),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .epc         (epc),
        .in_isr      (in_isr),
        .int_ack     (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        isr;
        logic        ack;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_isr, m_pend;
    logic        m_hist [0:SYNC];

    task automatic model_reset();
        m_pc   = RPC;
        m_epc  = '0;
        m_isr  = 1'b0;
        m_pend = 1'b0;
        for (int i = 0; i <= SYNC; i++) m_hist[i] = 1'b0;
    endtask

    // Predict the state after the coming clock edge from the current inputs.
    task automatic model_push();
        exp_t        e;
        logic [31:0] p4, nxt;
        logic        rise, take, cond;
        p4   = m_pc + 32'd4;
        cond = BNE ? !zero : zero;
        if (eret)
            nxt = m_epc;
        else if (Jr)
            nxt = rs_data;
        else if (Jump)
            nxt = (p4 & 32'hF000_0000) | (32'(instr_index) * 32'd4);
        else if (Branch && cond)
            nxt = p4 + 32'($signed(imm16) * 4);
        else
            nxt = p4;
        // A request edge sampled SYNC edges ago becomes pending now.
        rise = m_hist[SYNC-1] && !m_hist[SYNC];
        take = m_pend && !m_isr && !stall && !eret;
        e.ack = 1'b0;
        if (stall) begin
        end else if (take) begin
            m_epc = nxt;
            m_pc  = VEC;
            m_isr = 1'b1;
            e.ack = 1'b1;
        end else if (eret) begin
            m_pc  = m_epc;
            m_isr = 1'b0;
        end else begin
            m_pc = nxt;
        end
        m_pend = rise || (m_pend && !take);
        for (int i = SYNC; i >= 1; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int_req;
        e.pc  = m_pc;
        e.epc = m_epc;
        e.isr = m_isr;
        sb.push_back(e);
    endtask

    task automatic step();
        model_push();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        stall = 0; Branch = 0; BNE = 0; zero = 0; Jump = 0; Jr = 0; eret = 0;
        imm16 = '0; instr_index = '0; rs_data = '0;
    endtask

    task automatic jr_to(input logic [31:0] a);
        clear_ctl();
        Jr = 1; rs_data = a;
        step();
        clear_ctl();
    endtask

    // Monitor: compare every presented output state against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
                check("sb_epc", epc, e.epc);
                check("sb_in_isr", 32'(in_isr), 32'(e.isr));
                check("sb_int_ack", 32'(int_ack), 32'(e.ack));
            end
        end
    end

    int acks;

    initial begin
        clear_ctl();
        int_req = 0;
        rst = 1;
        model_reset();
        #2;
        check("rst_pc", pc, RPC);
        check("rst_epc", epc, 32'h0);
        check("rst_isr", 32'(in_isr), 32'h0);
        check("rst_ack", 32'(int_ack), 32'h0);
        @(negedge clk);
        rst = 0;
        check("seq_pc0", pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc, 32'(i * 4));
        end
        check("seq_epc", epc, 32'h0);
        check("seq_isr", 32'(in_isr), 32'h0);

        // Branches
        jr_to(32'h40);
        Branch = 1; BNE = 0; zero = 1; imm16 = 16'hFFFE;
        step();
        check("beq_taken", pc, 32'h3C);
        jr_to(32'h40);
        Branch = 1; BNE = 0; zero = 0; imm16 = 16'hFFFE;
        step();
        check("beq_not_taken", pc, 32'h44);
        jr_to(32'h40);
        Branch = 1; BNE = 1; zero = 0; imm16 = 16'hFFFE;
        step();
        check("bne_taken", pc, 32'h3C);

        // Jumps
        jr_to(32'hF000_0010);
        Jump = 1; instr_index = 26'h0000100;
        step();
        check("jump_tgt", pc, 32'hF000_0400);
        clear_ctl();
        Jr = 1; Jump = 1; rs_data = 32'h1234;
        step();
        check("jr_priority", pc, 32'h1234);

        // pc_plus4 wrap
        jr_to(32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        step();
        check("wrap_pc", pc, 32'h0);

        // Interrupt latency and single ack for a held level
        jr_to(32'h20);
        int_req = 1;
        for (int i = 0; i < SYNC + 1; i++) begin
            step();
            check("int_early_ack", 32'(int_ack), 32'h0);
        end
        step();
        check("int_ack", 32'(int_ack), 32'h1);
        check("int_pc", pc, VEC);
        check("int_epc", epc, 32'h30);
        check("int_isr", 32'(in_isr), 32'h1);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (int_ack) acks++;
        end
        check("held_level_acks", 32'(acks), 32'h0);

        // Second edge inside the ISR, taken right after eret
        int_req = 0;
        step(); step();
        int_req = 1;
        for (int i = 0; i < 4; i++) step();
        eret = 1;
        step();
        eret = 0;
        check("eret_pc", pc, 32'h30);
        check("eret_isr", 32'(in_isr), 32'h0);
        check("eret_ack", 32'(int_ack), 32'h0);
        step();
        check("reint_ack", 32'(int_ack), 32'h1);
        check("reint_pc", pc, VEC);
        check("reint_epc", epc, 32'h34);
        eret = 1;
        step();
        eret = 0;
        check("exit_pc", pc, 32'h34);
        check("exit_isr", 32'(in_isr), 32'h0);

        // Stall through a pending edge
        stall = 1;
        int_req = 0;
        step(); step();
        int_req = 1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (int_ack) acks++;
        end
        check("stall_acks", 32'(acks), 32'h0);
        check("stall_pc", pc, 32'h34);
        stall = 0;
        step();
        check("unstall_ack", 32'(int_ack), 32'h1);
        check("unstall_pc", pc, VEC);
        check("unstall_epc", epc, 32'h38);

        // Asynchronous reset while in the ISR with a request pending
        int_req = 0;
        step(); step();
        int_req = 1;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_isr", 32'(in_isr), 32'h1);
        #2;
        rst = 1;
        int_req = 0;
        sb.delete();
        model_reset();
        #1;
        check("arst_pc", pc, RPC);
        check("arst_epc", epc, 32'h0);
        check("arst_isr", 32'(in_isr), 32'h0);
        check("arst_ack", 32'(int_ack), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("arst_hold_pc", pc, RPC);
        rst = 0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (int_ack) acks++;
        end
        check("post_rst_acks", 32'(acks), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom % 5) == 0;
            Branch      = ($urandom % 4) == 0;
            BNE         = 1'($urandom);
            zero        = 1'($urandom);
            Jump        = ($urandom % 8) == 0;
            Jr          = ($urandom % 10) == 0;
            eret        = m_isr ? (($urandom % 6) == 0) : (($urandom % 30) == 0);
            imm16       = 16'($urandom);
            instr_index = 26'($urandom);
            rs_data     = $urandom;
            if (($urandom % 12) == 0) int_req = ~int_req;
            step();
        end
        clear_ctl();
        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
